alu_sequencer: RTL and testbench
================================

# alu_sequencer

Command-driven controller that sequences one ALU operation at a time and schedules updates of the Flag_Register. Accepts a command over a valid/ready handshake, optionally gates it on the current C/N/P/Z flags, drives the external combinational ALU, then pulses `enaf` with the result and carry so the flag register captures them, and returns the result over a valid/ready response port. Sits between the operand/command source and the ALU + Flag_Register pair.

## Interface
- MAX_WIDTH, 8, datapath width; shared with ALU and Flag_Register
- OP_WIDTH, 4, ALU opcode width
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  OP_WIDTH  ALU opcode, passed through unchanged
- cmd_a, cmd_b  in  MAX_WIDTH  operands
- cmd_cond  in  3  condition code: 000 always, 001 Z, 010 !Z, 011 C, 100 !C, 101 N, 110 !N, 111 P
- cmd_setf  in  1  1 = write result/carry into flag register
- alu_op  out  OP_WIDTH  registered opcode to ALU
- alu_a, alu_b  out  MAX_WIDTH  registered operands to ALU
- alu_result  in  MAX_WIDTH  combinational ALU result
- alu_carry  in  1  combinational ALU carry out
- enaf  out  1  flag-register enable, one-cycle pulse
- carry  out  1  carry to flag register
- dataa  out  MAX_WIDTH  result to flag register
- C, N, P, Z  in  1 each  current flag-register outputs
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer ready
- rsp_data  out  MAX_WIDTH  result (0 when skipped)
- rsp_skipped  out  1  command not executed, condition false
- busy  out  1  state != IDLE

## Operation
- States: IDLE, EVAL, EXEC, FLAG, RESP.
- IDLE: cmd_ready=1. On cmd_valid & cmd_ready, latch op/a/b/cond/setf → EVAL.
- EVAL: evaluate cmd_cond against C/N/P/Z sampled this cycle. True: load alu_op/alu_a/alu_b → EXEC. False: rsp_data=0, rsp_skipped=1 → RESP.
- EXEC: ALU inputs stable; register alu_result and alu_carry at end of cycle. setf=1 → FLAG, else → RESP.
- FLAG: enaf=1 for exactly this cycle; dataa/carry = latched result/carry; flag register captures at closing edge → RESP.
- RESP: rsp_valid=1, rsp_data/rsp_skipped held stable until rsp_ready=1 at an edge → IDLE.
- cmd_ready=0 in every state but IDLE; commands presented while busy are not accepted and are not lost by the source (handshake only).
- Skipped commands never reach FLAG; enaf stays 0 and flags are unchanged.
- Opcode is opaque; no arithmetic performed in this block.

## Timing
- Acceptance edge = T. EVAL cycle T+1, EXEC T+2, FLAG T+3 (if setf), rsp_valid high from T+4 (T+3 if setf=0, T+2 if skipped).
- Flags written at end of FLAG are visible on C/N/P/Z before the next command's EVAL (earliest EVAL is ≥2 cycles later); back-to-back conditional commands see prior results.
- Reset (rst=0 at an edge): state → IDLE; alu_op/alu_a/alu_b/dataa/rsp_data = 0; carry, enaf, rsp_valid, rsp_skipped, busy = 0; cmd_ready=1 from the first cycle after reset. enaf is forced 0 combinationally while rst=0.
- Reset mid-operation aborts: no enaf pulse, no response for the aborted command.
- cmd_valid and rsp_ready asserted in the same cycle as RESP→IDLE: new command accepted only from the following IDLE cycle (no RESP/IDLE overlap).

## Structure
- Package alu_seq_pkg: state enumeration, 3-bit condition-code constants, default OP_WIDTH.
- Sub-module cond_eval: combinational cond + C/N/P/Z → take. Everything else in alu_sequencer; Flag_Register and ALU remain external instances.

## Test plan
- Bench ALU model: op 0 = add. Reset with rst=0 two cycles → all outputs 0, cmd_ready=1 afterwards.
- add a=8'hFB b=8'h05 cond=000 setf=1 → enaf pulse exactly at T+3 with dataa=8'h00 carry=1; rsp_data=8'h00 at T+4; Z=1, C=1 afterward.
- Next cmd cond=010 (!Z) → rsp_skipped=1, rsp_data=0, no enaf; then cond=001 (Z) a=8'h70 b=8'h10 → rsp_data=8'h80, N=1 after FLAG.
- setf=0 add 8'h01+8'h01 → rsp_data=8'h02 at T+3, enaf never high, flags unchanged.
- Hold rsp_ready=0 five cycles → rsp_valid/rsp_data stable, cmd_ready=0 throughout, cmd_valid ignored.
- Assert rst=0 during EXEC → next cycle IDLE, no enaf, no rsp_valid.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: FSM states and condition codes.
package alu_seq_pkg;

    localparam int unsigned DEF_OP_WIDTH = 4;

    typedef enum logic [2:0] {
        IDLE,
        EVAL,
        EXEC,
        FLAG,
        RESP
    } state_t;

    localparam logic [2:0] CC_ALWAYS = 3'b000;
    localparam logic [2:0] CC_Z      = 3'b001;
    localparam logic [2:0] CC_NZ     = 3'b010;
    localparam logic [2:0] CC_C      = 3'b011;
    localparam logic [2:0] CC_NC     = 3'b100;
    localparam logic [2:0] CC_N      = 3'b101;
    localparam logic [2:0] CC_NN     = 3'b110;
    localparam logic [2:0] CC_P      = 3'b111;

endpackage

// File: rtl/alu_sequencer_cond_eval.sv
// Combinational condition-code check against the current flag-register outputs.
module cond_eval
    import alu_seq_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       C,
    input  logic       N,
    input  logic       P,
    input  logic       Z,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        case (cond)
            CC_ALWAYS: take = 1'b1;
            CC_Z:      take = Z;
            CC_NZ:     take = ~Z;
            CC_C:      take = C;
            CC_NC:     take = ~C;
            CC_N:      take = N;
            CC_NN:     take = ~N;
            CC_P:      take = P;
            default:   take = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU command at a time: condition gate, execute, optional flag update, response.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned MAX_WIDTH = 8,
    parameter int unsigned OP_WIDTH  = DEF_OP_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [OP_WIDTH-1:0]  cmd_op,
    input  logic [MAX_WIDTH-1:0] cmd_a,
    input  logic [MAX_WIDTH-1:0] cmd_b,
    input  logic [2:0]           cmd_cond,
    input  logic                 cmd_setf,
    output logic [OP_WIDTH-1:0]  alu_op,
    output logic [MAX_WIDTH-1:0] alu_a,
    output logic [MAX_WIDTH-1:0] alu_b,
    input  logic [MAX_WIDTH-1:0] alu_result,
    input  logic                 alu_carry,
    output logic                 enaf,
    output logic                 carry,
    output logic [MAX_WIDTH-1:0] dataa,
    input  logic                 C,
    input  logic                 N,
    input  logic                 P,
    input  logic                 Z,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [MAX_WIDTH-1:0] rsp_data,
    output logic                 rsp_skipped,
    output logic                 busy
);

    state_t                 state, next_state;
    logic [OP_WIDTH-1:0]    op_q;
    logic [MAX_WIDTH-1:0]   a_q, b_q;
    logic [2:0]             cond_q;
    logic                   setf_q;
    logic                   take;

    cond_eval u_cond_eval (
        .cond (cond_q),
        .C    (C),
        .N    (N),
        .P    (P),
        .Z    (Z),
        .take (take)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        enaf       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) next_state = EVAL;
            end
            EVAL: next_state = take ? EXEC : RESP;
            EXEC: next_state = setf_q ? FLAG : RESP;
            FLAG: begin
                // Gated by rst so an abort during FLAG never writes the flag register.
                enaf       = rst;
                next_state = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cond_q      <= '0;
            setf_q      <= 1'b0;
            alu_op      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            dataa       <= '0;
            carry       <= 1'b0;
            rsp_data    <= '0;
            rsp_skipped <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    op_q   <= cmd_op;
                    a_q    <= cmd_a;
                    b_q    <= cmd_b;
                    cond_q <= cmd_cond;
                    setf_q <= cmd_setf;
                end
                EVAL: if (take) begin
                    alu_op <= op_q;
                    alu_a  <= a_q;
                    alu_b  <= b_q;
                end else begin
                    rsp_data    <= '0;
                    rsp_skipped <= 1'b1;
                end
                EXEC: begin
                    dataa       <= alu_result;
                    carry       <= alu_carry;
                    rsp_data    <= alu_result;
                    rsp_skipped <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench: external ALU and flag register models plus a command-level reference.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_setf;
    logic [3:0] cmd_op, alu_op;
    logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, dataa, rsp_data;
    logic [2:0] cmd_cond;
    logic       alu_carry, enaf, carry;
    logic       fc, fn, fp, fz;
    logic       rsp_valid, rsp_ready, rsp_skipped, busy;

    logic       mc, mn, mp, mz;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.MAX_WIDTH(8), .OP_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cond(cmd_cond), .cmd_setf(cmd_setf),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .enaf(enaf), .carry(carry), .dataa(dataa),
        .C(fc), .N(fn), .P(fp), .Z(fz),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_skipped(rsp_skipped), .busy(busy)
    );

    function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {1'b0, a} - {1'b0, b};
            4'd2:    return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    function automatic logic cond_ok(input logic [2:0] cc, input logic c, input logic n, input logic p, input logic z);
        case (cc)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return c;
            3'd4:    return !c;
            3'd5:    return n;
            3'd6:    return !n;
            default: return p;
        endcase
    endfunction

    assign {alu_carry, alu_result} = alu_fn(alu_op, alu_a, alu_b);

    // Flag register: P is even parity of the captured result.
    always_ff @(posedge clk) begin
        if (!rst) {fc, fn, fp, fz} <= 4'b0000;
        else if (enaf) begin
            fc <= carry;
            fn <= dataa[7];
            fp <= ~^dataa;
            fz <= (dataa == 8'h00);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_alu_regs", {12'h0, alu_op, alu_a, alu_b}, 32'h0);
        check("rst_outputs", {11'h0, dataa, rsp_data, carry, enaf, rsp_valid, rsp_skipped, busy}, 32'h0);
        check("rst_cmd_ready", cmd_ready, 1);
    endtask

    // abort_k > 0 asserts reset at the negedge of that cycle after acceptance.
    task automatic do_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] cond, input logic setf, input int hold, input int abort_k);
        logic       take, exp_enaf;
        logic [8:0] res;
        logic [7:0] exp_data, got_d;
        logic       got_c;
        int         exp_lat, first_k, enaf_cnt, enaf_k, guard;
        bit         done;

        take     = cond_ok(cond, mc, mn, mp, mz);
        res      = alu_fn(op, a, b);
        exp_data = take ? res[7:0] : 8'h00;
        exp_enaf = take && setf;
        exp_lat  = !take ? 2 : (setf ? 4 : 3);
        first_k  = -1;
        enaf_cnt = 0;
        enaf_k   = -1;
        got_d    = '0;
        got_c    = 1'b0;
        done     = 0;

        @(negedge clk);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_cond = cond; cmd_setf = setf;
        cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("accept_timeout", guard < 20, 1);
        @(posedge clk);

        for (int k = 1; k <= 30 && !done; k++) begin
            @(negedge clk);
            // Source keeps offering junk while busy; it must be ignored.
            cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_cond = 3'($urandom);

            if (abort_k == k) begin
                rst = 1'b0;
                cmd_valid = 1'b0;
                #1 check("enaf_in_rst", enaf, 0);
                @(negedge clk);
                check_reset_state();
                rst = 1'b1;
                {mc, mn, mp, mz} = 4'b0000;
                for (int j = 0; j < 6; j++) begin
                    @(negedge clk);
                    check("abort_quiet", {enaf, rsp_valid, busy}, 3'b000);
                end
                return;
            end

            if (enaf) begin
                enaf_cnt++;
                enaf_k = k;
                got_d  = dataa;
                got_c  = carry;
            end
            if (rsp_valid && first_k < 0) first_k = k;
            check("busy_ready", cmd_ready, 0);
            if (first_k >= 0) begin
                check("rsp_data", rsp_data, exp_data);
                check("rsp_skipped", rsp_skipped, !take);
                check("rsp_valid_held", rsp_valid, 1);
                if (k - first_k >= hold) begin
                    rsp_ready = 1'b1;
                    @(negedge clk);
                    rsp_ready = 1'b0;
                    check("idle_after_rsp", {rsp_valid, cmd_ready, busy}, 3'b010);
                    cmd_valid = 1'b0;
                    done = 1;
                end
            end
        end

        if (!done) begin
            check("rsp_timeout", 0, 1);
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        check("latency", first_k, exp_lat);
        check("enaf_count", enaf_cnt, exp_enaf);
        if (exp_enaf) begin
            check("enaf_cycle", enaf_k, 3);
            check("flag_dataa", got_d, res[7:0]);
            check("flag_carry", got_c, res[8]);
            mc = res[8];
            mn = res[7];
            mp = ~^res[7:0];
            mz = (res[7:0] == 8'h00);
        end
        check("flags", {fc, fn, fp, fz}, {mc, mn, mp, mz});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_cond = '0; cmd_setf = 1'b0;
        {mc, mn, mp, mz} = 4'b0000;
        repeat (2) @(negedge clk);
        check_reset_state();
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {cmd_ready, busy}, 2'b10);

        do_cmd(4'd0, 8'hFB, 8'h05, 3'b000, 1'b1, 0, 0);
        check("dir_ZC", {fz, fc}, 2'b11);
        do_cmd(4'd0, 8'h12, 8'h34, 3'b010, 1'b1, 0, 0);
        do_cmd(4'd0, 8'h70, 8'h10, 3'b001, 1'b1, 0, 0);
        check("dir_N", fn, 1);
        do_cmd(4'd0, 8'h01, 8'h01, 3'b000, 1'b0, 0, 0);
        do_cmd(4'd0, 8'h21, 8'h02, 3'b000, 1'b1, 5, 0);
        do_cmd(4'd0, 8'hFF, 8'h01, 3'b000, 1'b1, 0, 2);
        do_cmd(4'd1, 8'h05, 8'h09, 3'b000, 1'b1, 0, 3);

        for (int i = 0; i < 60; i++) begin
            do_cmd(4'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                   3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
